// File: rtl/ctrl_fsm.sv
// Multicycle FETCH/DECODE/EXE/MEM/WB sequencer owning the shared memory-bus handshake; 4 cycles per ALU op, 5 per load/store at zero wait.
// Bus backpressure: bus_req holds (with stable bus_data) until bus_ack; every wait cycle adds one cycle. Outputs registered except ir_we/rf_we.
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  exe_next,
  input  logic        reg_write,
  input  logic        illegal,
  input  logic        sys_halt,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_data,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        retire,
  output logic [31:0] instret,
  output logic [2:0]  state,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        run_q, run_d;
  logic        fault_q, fault_d;
  logic [31:0] instret_q, instret_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_data_q, bus_data_d;
  logic        pc_we_q, pc_we_d;
  logic        retire_q, retire_d;
  logic        halted_q, halted_d;

  always_comb begin
    state_d   = state_q;
    run_d     = 1'b1;
    fault_d   = fault_q;
    instret_d = instret_q;
    case (state_q)
      FETCH: begin
        // run_q gates the first post-reset cycle so the bus stays idle
        if (run_q && bus_ack) state_d = DECODE;
      end
      DECODE: begin
        if (illegal) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else if (sys_halt) begin
          state_d = HALT;
        end else begin
          state_d = EXE;
        end
      end
      EXE: begin
        case (state_t'(exe_next))
          MEM:     state_d = MEM;
          WB:      state_d = WB;
          default: begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      MEM: begin
        if (bus_ack) state_d = WB;
      end
      WB: begin
        state_d   = FETCH;
        instret_d = instret_q + 32'd1;
      end
      HALT: state_d = HALT;
      default: begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    endcase

    // Moore outputs are registered by decoding the next state
    bus_req_d  = (state_d == FETCH) || (state_d == MEM);
    bus_data_d = (state_d == MEM);
    pc_we_d    = (state_d == WB);
    retire_d   = (state_d == WB);
    halted_d   = (state_d == HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      fault_q    <= 1'b0;
      instret_q  <= 32'd0;
      bus_req_q  <= 1'b0;
      bus_data_q <= 1'b0;
      pc_we_q    <= 1'b0;
      retire_q   <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      fault_q    <= fault_d;
      instret_q  <= instret_d;
      bus_req_q  <= bus_req_d;
      bus_data_q <= bus_data_d;
      pc_we_q    <= pc_we_d;
      retire_q   <= retire_d;
      halted_q   <= halted_d;
    end
  end

  assign ir_we    = bus_req_q & ~bus_data_q & bus_ack;
  assign rf_we    = pc_we_q & reg_write;
  assign bus_req  = bus_req_q;
  assign bus_data = bus_data_q;
  assign pc_we    = pc_we_q;
  assign retire   = retire_q;
  assign instret  = instret_q;
  assign state    = state_q;
  assign halted   = halted_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Randomized bench for ctrl_fsm: each instruction is expanded into its expected phase sequence and every cycle is checked.
module tb_ctrl_fsm;

  localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXE = 3'd2,
                         S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5;
  localparam int K_ALU = 0, K_MEM = 1, K_ILL = 2, K_SYS = 3, K_BAD = 4, K_BOTH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  exe_next = 3'd0;
  logic        reg_write = 1'b0, illegal = 1'b0, sys_halt = 1'b0, bus_ack = 1'b0;
  logic        bus_req, bus_data, ir_we, pc_we, rf_we, retire, halted, fault;
  logic [31:0] instret;
  logic [2:0]  state;

  int n_err = 0;
  int n_chk = 0;
  int req_obs = 0;
  int rf_obs = 0;

  logic [31:0] ic_m = 32'd0;
  logic        flt_m = 1'b0;
  logic        run_m = 1'b0;

  always #5 clk = ~clk;

  ctrl_fsm dut (
    .clk(clk), .rst(rst), .exe_next(exe_next), .reg_write(reg_write),
    .illegal(illegal), .sys_halt(sys_halt), .bus_ack(bus_ack),
    .bus_req(bus_req), .bus_data(bus_data), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .retire(retire), .instret(instret), .state(state),
    .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One cycle in an expected phase: drive inputs, check outputs mid-low-phase, advance.
  task automatic cyc(input logic [2:0] st, input logic ack, input logic ill,
                     input logic sh, input logic [2:0] xn, input logic rw);
    bus_ack = ack; illegal = ill; sys_halt = sh; exe_next = xn; reg_write = rw;
    #1;
    check("state",    32'(state),    32'(st));
    check("bus_req",  32'(bus_req),  32'(((st == S_FETCH) && run_m) || (st == S_MEM)));
    check("bus_data", 32'(bus_data), 32'(st == S_MEM));
    check("ir_we",    32'(ir_we),    32'((st == S_FETCH) && run_m && ack));
    check("pc_we",    32'(pc_we),    32'(st == S_WB));
    check("rf_we",    32'(rf_we),    32'((st == S_WB) && rw));
    check("retire",   32'(retire),   32'(st == S_WB));
    check("halted",   32'(halted),   32'(st == S_HALT));
    check("fault",    32'(fault),    32'(flt_m));
    check("instret",  instret,       ic_m);
    req_obs += int'(bus_req);
    rf_obs  += int'(rf_we);
    @(posedge clk);
    if (st == S_WB) ic_m = ic_m + 32'd1;
    run_m = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_instr(input int fw, input int kind, input int mw, input logic rw,
                          input logic spur, input logic [2:0] bxn);
    logic [2:0] xn;
    for (int i = 0; i <= fw; i++) cyc(S_FETCH, i == fw, rbit(), rbit(), 3'($urandom), rbit());
    cyc(S_DECODE, spur | rbit(), (kind == K_ILL) || (kind == K_BOTH),
        (kind == K_SYS) || (kind == K_BOTH), 3'($urandom), rbit());
    if ((kind == K_ILL) || (kind == K_BOTH)) begin
      flt_m = 1'b1;
      return;
    end
    if (kind == K_SYS) return;
    xn = (kind == K_MEM) ? 3'd3 : (kind == K_BAD) ? bxn : 3'd4;
    cyc(S_EXE, spur | rbit(), rbit(), rbit(), xn, rbit());
    if (kind == K_BAD) begin
      flt_m = 1'b1;
      return;
    end
    if (kind == K_MEM)
      for (int i = 0; i <= mw; i++) cyc(S_MEM, i == mw, rbit(), rbit(), 3'($urandom), rbit());
    cyc(S_WB, spur | rbit(), rbit(), rbit(), 3'($urandom), rw);
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(S_HALT, rbit(), rbit(), rbit(), 3'($urandom), rbit());
  endtask

  // Asserts reset wherever the run currently is, then releases on a falling edge.
  task automatic reset_dut(input int hold);
    rst = 1'b0;
    bus_ack = 1'b1;
    #1;
    check("rst_state",   32'(state),    32'(S_FETCH));
    check("rst_bus_req", 32'(bus_req),  32'd0);
    check("rst_bus_dat", 32'(bus_data), 32'd0);
    check("rst_ir_we",   32'(ir_we),    32'd0);
    check("rst_pc_we",   32'(pc_we),    32'd0);
    check("rst_rf_we",   32'(rf_we),    32'd0);
    check("rst_retire",  32'(retire),   32'd0);
    check("rst_halted",  32'(halted),   32'd0);
    check("rst_fault",   32'(fault),    32'd0);
    check("rst_instret", instret,       32'd0);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    ic_m = 32'd0;
    flt_m = 1'b0;
    run_m = 1'b0;
    cyc(S_FETCH, 1'b1, rbit(), rbit(), 3'($urandom), rbit());
  endtask

  logic [2:0] bad_tbl [6] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7};

  initial begin
    #2;
    reset_dut(3);

    // ALU with reg_write, zero-wait
    do_instr(0, K_ALU, 0, 1'b1, 1'b0, 3'd0);
    check("alu_instret", instret, 32'd1);

    // Load with 3 fetch and 2 MEM wait cycles
    req_obs = 0; rf_obs = 0;
    do_instr(3, K_MEM, 2, 1'b1, 1'b0, 3'd0);
    check("wait_req_cycles", 32'(req_obs), 32'd7);
    check("wait_rf_pulses",  32'(rf_obs),  32'd1);

    // Store
    rf_obs = 0;
    do_instr(0, K_MEM, 0, 1'b0, 1'b0, 3'd0);
    check("store_rf_pulses", 32'(rf_obs), 32'd0);

    // Spurious acks outside request phases
    do_instr(1, K_ALU, 0, 1'b1, 1'b1, 3'd0);
    do_instr(0, K_MEM, 1, 1'b0, 1'b1, 3'd0);

    for (int n = 0; n < 30; n++)
      do_instr($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), rbit(), rbit(), 3'd0);

    // Counter wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    ic_m = 32'hFFFF_FFFF;
    do_instr(0, K_ALU, 0, 1'b1, 1'b0, 3'd0);
    check("wrap_instret", instret, 32'd0);
    do_instr(0, K_ALU, 0, 1'b0, 1'b0, 3'd0);

    // Reset while MEM waits for ack
    cyc(S_FETCH, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(S_DECODE, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(S_EXE, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0);
    cyc(S_MEM, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(S_MEM, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    bus_ack = 1'b0;
    #1;
    check("abort_req_before", 32'(bus_req), 32'd1);
    check("abort_instret",    instret,      ic_m);
    #1;
    reset_dut(2);
    do_instr(0, K_ALU, 0, 1'b1, 1'b0, 3'd0);

    // Illegal opcode: sticky fault halt, bus idle despite acks
    do_instr(1, K_ILL, 0, 1'b0, 1'b0, 3'd0);
    halt_cycles(6);
    reset_dut(2);
    do_instr(0, K_ALU, 0, 1'b1, 1'b0, 3'd0);

    // illegal beats sys_halt
    do_instr(0, K_BOTH, 0, 1'b0, 1'b0, 3'd0);
    halt_cycles(3);
    reset_dut(1);

    // ecall/ebreak halt without fault
    do_instr(2, K_SYS, 0, 1'b0, 1'b1, 3'd0);
    halt_cycles(4);
    reset_dut(1);

    // Bad exe_next codes
    do_instr(0, K_BAD, 0, 1'b0, 1'b0, 3'd7);
    halt_cycles(3);
    for (int n = 0; n < 4; n++) begin
      reset_dut(1);
      do_instr(0, K_ALU, 0, rbit(), 1'b0, 3'd0);
      do_instr($urandom_range(0, 2), K_BAD, 0, 1'b0, rbit(), bad_tbl[$urandom_range(0, 5)]);
      halt_cycles(2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
